// File: rtl/pinfilter_bank.sv
// pinfilter_bank: multi-channel GPIO noise filter and edge detector.
//
// Each of WIDTH raw pin lines passes through a two-flop synchroniser and a
// per-channel run counter. A channel commits a new filtered level only after
// DEPTH consecutive enabled samples that differ from its current level. Any
// enabled sample of the old level throws the partial run away.
//
// Parameters:
//   WIDTH     number of independent channels (1..32)
//   DEPTH     consecutive differing enabled samples needed to commit (1..256)
//   RESET_VAL level of synchroniser and dout after reset
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   din        raw asynchronous pin levels
//   ena        sample strobe; counters and dout advance only when high
//   dout       filtered, registered levels
//   rise       one-clk strobe per channel on a committed 0->1
//   fall       one-clk strobe per channel on a committed 1->0
//   changed    registered OR of rise|fall (cleared on edges with ena low)
//   glitch_clr clears glitch_cnt (glitch counter build only)
//   glitch_cnt saturating count of enabled edges that rejected a glitch
//
// Optional feature macro: PINFILTER_GLITCH_CNT_EN. When undefined,
// glitch_cnt is tied to zero and glitch_clr is ignored.
module pinfilter_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  input  logic             glitch_clr,
  output logic [15:0]      glitch_cnt
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Count value at which the next differing enabled sample commits.
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             glitch_any;

  always_comb begin
    dout_d     = dout_q;
    rise_d     = '0;
    fall_d     = '0;
    glitch_any = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ena) begin
        if (s2_q[i] != dout_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            dout_d[i] = s2_q[i];
            cnt_d[i]  = '0;
            rise_d[i] = s2_q[i];
            fall_d[i] = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          // Sample matches the committed level: a non-zero run was noise.
          if (cnt_q[i] != '0) glitch_any = 1'b1;
          cnt_d[i] = '0;
        end
      end
    end
    // changed trails the strobes by one clk and, like them, is forced low
    // on edges where ena is low.
    changed_d = ena & (|(rise_q | fall_q));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q      <= RESET_VAL;
      s2_q      <= RESET_VAL;
      dout_q    <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= din;
      s2_q      <= s1_q;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

`ifdef PINFILTER_GLITCH_CNT_EN
  logic [15:0] gcnt_q;

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gcnt_q <= '0;
    end else if (glitch_clr) begin
      gcnt_q <= '0;
    end else if (glitch_any && (gcnt_q != 16'hFFFF)) begin
      gcnt_q <= gcnt_q + 16'd1;
    end
  end

  assign glitch_cnt = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_clr ^ glitch_any;
  assign glitch_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_pinfilter_bank.sv
// Bench for pinfilter_bank: two instances (DEPTH=2 and DEPTH=4) share one
// stimulus stream; a per-edge reference model built from the filter rules
// (delayed samples, run lengths of differing enabled samples) predicts every
// output, and directed steps check the documented scenarios with constants.
module tb_pinfilter_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       ena;
  logic       glitch_clr;

  logic [7:0]  dout2, rise2, fall2, dout4, rise4, fall4;
  logic        changed2, changed4;
  logic [15:0] gcnt2, gcnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pinfilter_bank #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .din(din), .ena(ena),
    .dout(dout2), .rise(rise2), .fall(fall2), .changed(changed2),
    .glitch_clr(glitch_clr), .glitch_cnt(gcnt2)
  );

  pinfilter_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .din(din), .ena(ena),
    .dout(dout4), .rise(rise4), .fall(fall4), .changed(changed4),
    .glitch_clr(glitch_clr), .glitch_cnt(gcnt4)
  );

  // Reference model state, index 0 -> DEPTH 2, index 1 -> DEPTH 4.
  logic [7:0] m_s1 [2];
  logic [7:0] m_s2 [2];
  logic [7:0] m_dout [2];
  logic [7:0] m_rise [2];
  logic [7:0] m_fall [2];
  logic       m_changed [2];
  int         m_gcnt [2];
  int         m_run [2][8];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs as they were
  // just before that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_s1[k] = 8'hFF; m_s2[k] = 8'hFF; m_dout[k] = 8'hFF;
        m_rise[k] = 8'h00; m_fall[k] = 8'h00; m_changed[k] = 1'b0;
        m_gcnt[k] = 0;
        for (int c = 0; c < 8; c++) m_run[k][c] = 0;
      end else begin
        logic [7:0] nd, nr, nf;
        bit glitch;
        nd = m_dout[k]; nr = 8'h00; nf = 8'h00; glitch = 0;
        if (ena) begin
          for (int c = 0; c < 8; c++) begin
            if (m_s2[k][c] != m_dout[k][c]) begin
              m_run[k][c] = m_run[k][c] + 1;
              if (m_run[k][c] == dep(k)) begin
                nd[c] = m_s2[k][c];
                m_run[k][c] = 0;
                if (m_s2[k][c]) nr[c] = 1'b1;
                else            nf[c] = 1'b1;
              end
            end else begin
              if (m_run[k][c] != 0) glitch = 1;
              m_run[k][c] = 0;
            end
          end
        end
        m_changed[k] = ena && ((m_rise[k] | m_fall[k]) != 8'h00);
        m_rise[k] = nr;
        m_fall[k] = nf;
        m_dout[k] = nd;
        m_s2[k] = m_s1[k];
        m_s1[k] = din;
`ifdef PINFILTER_GLITCH_CNT_EN
        if (glitch_clr) m_gcnt[k] = 0;
        else if (glitch && m_gcnt[k] < 65535) m_gcnt[k] = m_gcnt[k] + 1;
`else
        m_gcnt[k] = 0;
`endif
      end
    end
  endtask

  task automatic compare_all();
    chk("dout_d2", dout2, m_dout[0]);
    chk("rise_d2", rise2, m_rise[0]);
    chk("fall_d2", fall2, m_fall[0]);
    chk("changed_d2", changed2, m_changed[0]);
    chk("gcnt_d2", gcnt2, m_gcnt[0]);
    chk("dout_d4", dout4, m_dout[1]);
    chk("rise_d4", rise4, m_rise[1]);
    chk("fall_d4", fall4, m_fall[1]);
    chk("changed_d4", changed4, m_changed[1]);
    chk("gcnt_d4", gcnt4, m_gcnt[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic settle(input int n);
    din = 8'hFF; ena = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] seen;
    logic [7:0] fall_val;
    int         fall_edges;
    int         gexp;

    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 8'hFF; m_s2[k] = 8'hFF; m_dout[k] = 8'hFF;
      m_rise[k] = 0; m_fall[k] = 0; m_changed[k] = 0; m_gcnt[k] = 0;
      for (int c = 0; c < 8; c++) m_run[k][c] = 0;
    end

    // Reset with din low: everything must sit at the idle-high state.
    reset_n = 1'b0; din = 8'h00; ena = 1'b0; glitch_clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_dout", dout2, 8'hFF);
    chk("rst_rise", rise2, 8'h00);
    chk("rst_fall", fall2, 8'h00);
    chk("rst_changed", changed2, 1'b0);
    chk("rst_gcnt", gcnt2, 16'h0000);
    chk("rst_dout4", dout4, 8'hFF);

    // Clean fall on channel 0, DEPTH 2: commit at edge 4, changed at edge 5.
    reset_n = 1'b1;
    settle(6);
    din = 8'hFE;
    tick(); tick(); tick();
    chk("fall_e3_dout", dout2, 8'hFF);
    chk("fall_e3_fall", fall2, 8'h00);
    tick();
    chk("fall_e4_dout", dout2, 8'hFE);
    chk("fall_e4_fall", fall2, 8'h01);
    chk("fall_e4_chg", changed2, 1'b0);
    tick();
    chk("fall_e5_fall", fall2, 8'h00);
    chk("fall_e5_chg", changed2, 1'b1);
    tick();
    chk("fall_e6_dout4", dout4, 8'hFE);
    chk("fall_e6_fall4", fall4, 8'h01);
    settle(10);

    // Glitch on channel 3 for three clks: DEPTH 4 must reject it.
    gexp = m_gcnt[1] + 1;
    seen = 8'h00;
    din = 8'hF7;
    for (int i = 0; i < 3; i++) begin tick(); seen |= rise4 | fall4; end
    din = 8'hFF;
    for (int i = 0; i < 8; i++) begin tick(); seen |= rise4 | fall4; end
    chk("glitch_dout4", dout4, 8'hFF);
    chk("glitch_nostrobe4", seen, 8'h00);
`ifdef PINFILTER_GLITCH_CNT_EN
    chk("glitch_cnt4", gcnt4, gexp[15:0]);
`endif
    settle(10);

    // ena every 4th clk, channel 7 falls; no strobe on disabled edges.
    din = 8'h7F;
    for (int i = 0; i < 24; i++) begin
      ena = (i % 4 == 3);
      tick();
      if (!ena) chk("gate_nostrobe", {rise2 | fall2 | rise4 | fall4, changed2, changed4}, 10'h0);
    end
    chk("gate_dout2", dout2, 8'h7F);
    chk("gate_dout4", dout4, 8'h7F);
    settle(10);

    // Four channels fall together on a single edge.
    din = 8'h0F;
    fall_edges = 0; fall_val = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fall2 != 8'h00) begin fall_edges++; fall_val = fall2; end
    end
    chk("multi_edges", fall_edges, 1);
    chk("multi_fall", fall_val, 8'hF0);
    chk("multi_dout", dout2, 8'h0F);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      din        = din ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ena        = ($urandom_range(0, 3) != 0);
      glitch_clr = ($urandom_range(0, 15) == 0);
      reset_n    = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset_n = 1'b1; glitch_clr = 1'b0;
    settle(10);

`ifdef PINFILTER_GLITCH_CNT_EN
    // Two channels glitch out of phase so every enabled edge rejects one.
    for (int i = 0; i < 66000; i++) begin
      din = (i % 2 == 1) ? 8'hFD : 8'hFE;
      tick();
    end
    chk("sat_gcnt2", gcnt2, 16'hFFFF);
    chk("sat_gcnt4", gcnt4, 16'hFFFF);
    glitch_clr = 1'b1;
    din = 8'hFE;
    tick();
    chk("clr_gcnt2", gcnt2, 16'h0000);
    glitch_clr = 1'b0;
    din = 8'hFD;
    tick();
    chk("post_clr_gcnt2", gcnt2, 16'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
